// File: rtl/cubic_root_param.sv
// Parametrised integer root unit: floor cube root or floor square root of an
// unsigned WIDTH-bit operand, with remainder. Cube mode uses a restoring
// digit-by-digit algorithm whose 3y(y+1) term comes from a bit-serial
// shift-add multiplier; square mode uses the classic one-bit-per-cycle method.
module cubic_root_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] x_bi,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] y_bo,
    output logic [WIDTH-1:0] r_bo
);

    localparam int unsigned K3 = (WIDTH + 2) / 3;  // cube-root iterations
    localparam int unsigned K2 = (WIDTH + 1) / 2;  // square-root iterations
    localparam int unsigned BW = WIDTH + 3;        // comparator / subtrahend width
    localparam int unsigned PW = 2 * K3 + 3;       // product register width
    localparam int unsigned MB = K3 + 1;           // multiplier operand b width

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        STEP,
        MUL,
        CMP,
        DONE
    } state_t;

    state_t           state_q, state_nx;
    logic [WIDTH-1:0] x_q, x_nx;
    logic [WIDTH-1:0] y_q, y_nx;
    logic [WIDTH-1:0] m_q, m_nx;
    logic [5:0]       s_q, s_nx;
    logic [5:0]       cnt_q, cnt_nx;
    logic [PW-1:0]    a_q, a_nx;
    logic [MB-1:0]    b_q, b_nx;
    logic [PW-1:0]    prod_q, prod_nx;
    logic             res_ld;

    logic [BW-1:0]    sq_b;
    logic [BW-1:0]    cmp_b;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] y_dbl;
    logic [PW-1:0]    a_ld;

    // State and datapath registers; result registers load on entry to DONE
    // so the root and remainder are already valid while done_o is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            m_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            y_bo    <= '0;
            r_bo    <= '0;
        end else begin
            state_q <= state_nx;
            x_q     <= x_nx;
            y_q     <= y_nx;
            m_q     <= m_nx;
            s_q     <= s_nx;
            cnt_q   <= cnt_nx;
            a_q     <= a_nx;
            b_q     <= b_nx;
            prod_q  <= prod_nx;
            if (res_ld) begin
                y_bo <= y_nx;
                r_bo <= x_nx;
            end
        end
    end

    // Next-state and datapath update for every state.
    always_comb begin
        state_nx = state_q;
        x_nx     = x_q;
        y_nx     = y_q;
        m_nx     = m_q;
        s_nx     = s_q;
        cnt_nx   = cnt_q;
        a_nx     = a_q;
        b_nx     = b_q;
        prod_nx  = prod_q;
        res_ld   = 1'b0;

        sq_b  = BW'(y_q | m_q);
        y_sh  = y_q >> 1;
        y_dbl = y_q << 1;
        a_ld  = PW'(y_dbl);
        cmp_b = (BW'(prod_q) + BW'(1)) << s_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_nx = x_bi;
                    y_nx = '0;
                    if (mode_i) begin
                        m_nx     = WIDTH'(1) << (2 * (K2 - 1));
                        state_nx = SQ;
                    end else begin
                        s_nx     = 6'(3 * (K3 - 1));
                        state_nx = STEP;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            SQ: begin
                if (BW'(x_q) >= sq_b) begin
                    x_nx = x_q - WIDTH'(sq_b);
                    y_nx = y_sh | m_q;
                end else begin
                    y_nx = y_sh;
                end
                m_nx = m_q >> 2;
                // mask reaches bit 0 on the last iteration
                if (m_q == WIDTH'(1)) begin
                    state_nx = DONE;
                    res_ld   = 1'b1;
                end
            end
            STEP: begin
                y_nx     = y_dbl;
                a_nx     = (a_ld << 1) + a_ld;
                b_nx     = MB'(y_dbl + WIDTH'(1));
                prod_nx  = '0;
                cnt_nx   = 6'(K3);
                state_nx = MUL;
            end
            MUL: begin
                if (b_q[0]) begin
                    prod_nx = prod_q + a_q;
                end
                a_nx   = a_q << 1;
                b_nx   = b_q >> 1;
                cnt_nx = cnt_q - 6'd1;
                if (cnt_q == '0) begin
                    state_nx = CMP;
                end
            end
            CMP: begin
                if (BW'(x_q) >= cmp_b) begin
                    x_nx = x_q - WIDTH'(cmp_b);
                    y_nx = y_q + WIDTH'(1);
                end
                if (s_q == '0) begin
                    state_nx = DONE;
                    res_ld   = 1'b1;
                end else begin
                    s_nx     = s_q - 6'd3;
                    state_nx = STEP;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == SQ) || (state_q == STEP) ||
                    (state_q == MUL) || (state_q == CMP);
    assign done_o = (state_q == DONE);

endmodule

// File: doc/cubic_root_param.md
# cubic_root_param

Parametrised integer root unit: computes either floor(cube root) or floor(square root) of an unsigned WIDTH-bit operand, plus the remainder, using a start/busy handshake and an internal bit-serial shift-add multiplier. It succeeds the fixed 8-bit cube-root block. It sits beside the shared `mult` datapath blocks and is driven by the same kind of sequencer.

## Interface
- WIDTH, 8, operand width in bits; legal range 4..32
- K3 (localparam), ceil(WIDTH/3), cube-root iteration count
- K2 (localparam), ceil(WIDTH/2), square-root iteration count
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only when the unit can accept
- mode_i  in  1  0 = cube root, 1 = square root; sampled with start
- x_bi  in  WIDTH  unsigned operand; sampled with start
- busy_o  out  1  high while an operation is in progress
- done_o  out  1  one-cycle pulse; results valid in this cycle
- y_bo  out  WIDTH  root, zero-extended
- r_bo  out  WIDTH  remainder: x − y³ (cube) or x − y² (square)

## Operation
- States: IDLE, SQ, STEP, MUL, CMP, DONE.
- Start is accepted in IDLE or DONE when start=1. At accept, the unit latches x_bi and mode_i, and clears the working root y to 0.
  - mode 0: the shift s is loaded with 3·(K3−1); next state is STEP.
  - mode 1: the mask m is loaded with 1<<(2·(K2−1)); next state is SQ.
- start in any other state is ignored. It is not queued.
- SQ, one cycle per iteration, K2 iterations:
  - b = y|m; y' = y>>1.
  - If x ≥ b: x −= b and y' |= m.
  - m >>= 2.
  - After the K2-th iteration, go to DONE.
- STEP, one cycle: y <= 2y. The multiplier is loaded with a = 3y and b = y+1, using the new y, and the product is cleared.
- MUL, exactly K3+1 cycles: the multiplier consumes one bit of b per cycle, LSB first, adding the shifted a into the product.
- CMP, one cycle:
  - b = (prod+1)<<s.
  - If x ≥ b: x −= b and y += 1.
  - If s = 0, go to DONE. Otherwise s −= 3 and go to STEP.
- DONE, one cycle:
  - y_bo <= y, r_bo <= remaining x, done_o = 1, busy_o = 0.
  - If start=1 in this cycle, the next operation is accepted (back-to-back). Otherwise go to IDLE.
- Width rules:
  - The comparator, subtractor and b are WIDTH+3 bits wide, so there is no overflow for any x.
  - The product register is 2·K3+3 bits.
  - The root never exceeds K3 bits (cube) or K2 bits (square).
- y_bo and r_bo hold their last result until the next DONE. They do not change while busy.
- Reset at any time, including mid-operation:
  - State goes to IDLE and all outputs go to 0.
  - No done_o pulse is produced for the aborted operation.

## Timing
- Reset values: busy_o=0, done_o=0, y_bo=0, r_bo=0.
- Accept edge t: busy_o=1 from cycle t+1.
- Cube mode:
  - busy_o is high for exactly K3·(K3+3) cycles.
  - For WIDTH=8 this is 3·6 = 18 cycles; done_o is high in cycle t+19.
- Square mode:
  - busy_o is high for exactly K2 cycles.
  - For WIDTH=8 this is 4 cycles; done_o is high in cycle t+5.
- busy_o and done_o are never high in the same cycle.
- Latency is data-independent.
- Back-to-back: start held high through DONE gives busy_o=1 in the cycle after done_o, with no IDLE gap.

## Test plan
- Cube, WIDTH=8:
  - x=27 → y=3, r=0.
  - x=255 → y=6, r=39.
  - x=0 → y=0, r=0.
  - For each, done_o comes exactly 19 cycles after accept.
- Square, WIDTH=8:
  - x=200 → y=14, r=4.
  - x=255 → y=15, r=30.
  - x=1 → y=1, r=0.
  - For each, done_o comes exactly 5 cycles after accept.
- Start pulsed with x=8 during an active cube operation on x=125:
  - The second start is ignored.
  - Result is y=5, r=0, with a single done_o pulse.
- Reset asserted mid-MUL:
  - All outputs are 0 next cycle and no done_o pulse follows.
  - A new start with x=64 (cube) then returns y=4, r=0.
- Back-to-back: cube x=64 followed by start held in DONE for square x=64:
  - First result y=4, r=0.
  - Second result y=8, r=0.
  - No idle cycle between the two operations.
- WIDTH=16, exhaustive sweep of x in both modes, compared with a reference model:
  - y³ ≤ x < (y+1)³ and r = x − y³ (cube).
  - y² ≤ x < (y+1)² and r = x − y² (square).
  - Fixed latencies: cube 6·9+1 = 55 cycles, square 8+1 = 9 cycles, accept edge to done_o.
